// File: rtl/muldiv_unit_if.sv
// Issue/result handshake bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_op;
    logic [DATA_WIDTH-1:0] in_src1;
    logic [DATA_WIDTH-1:0] in_src2;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [TAG_WIDTH-1:0]  out_tag;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit: registered multiplier plus a fixed-latency radix-2 restoring divider.
// state | meaning
// IDLE  | waiting for an issue
// MUL   | multiply in flight, cnt_q counts down the remaining stages
// DIV   | divide: operand load, W iterations, sign fix-up (cnt_q = W+1 .. 0)
// DONE  | result held until consumed
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_WIDTH  = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    muldiv_unit_if.slave bus,
    output logic         busy
);
    localparam int W       = DATA_WIDTH;
    localparam int CNT_MAX = (W + 1 > MUL_STAGES) ? W + 1 : MUL_STAGES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DIV_LOAD = CW'(W + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_STAGES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MOD   = 3'd5;
    localparam logic [2:0] OP_MODU  = 3'd6;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [W-1:0]         src1_q, src1_d;
    logic [W-1:0]         src2_q, src2_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [W-1:0]         rem_q, rem_d;
    logic [W-1:0]         quo_q, quo_d;
    logic [W-1:0]         dvs_q, dvs_d;
    logic [W-1:0]         result_q, result_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

    logic                 accept;
    logic                 in_is_div;
    logic                 signed_div;
    logic                 is_mod;
    logic                 neg_src1;
    logic                 neg_src2;
    logic                 mul_sext;
    logic [2*W-1:0]       mul_a;
    logic [2*W-1:0]       mul_b;
    logic [2*W-1:0]       product;
    logic [W-1:0]         mul_res;
    logic [W:0]           div_shift;
    logic [W:0]           div_diff;
    logic [W-1:0]         div_res;

    function automatic logic [W-1:0] negate(input logic [W-1:0] x);
        return ~x + {{(W-1){1'b0}}, 1'b1};
    endfunction

    assign bus.in_ready   = (state_q == S_IDLE) && !flush && !rst;
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = result_q;
    assign bus.out_tag    = out_tag_q;
    assign busy           = (state_q != S_IDLE);

    assign accept    = bus.in_valid && bus.in_ready;
    assign in_is_div = (bus.in_op >= OP_DIV) && (bus.in_op <= OP_MODU);

    assign signed_div = (op_q == OP_DIV) || (op_q == OP_MOD);
    assign is_mod     = (op_q == OP_MOD) || (op_q == OP_MODU);
    assign neg_src1   = signed_div && src1_q[W-1];
    assign neg_src2   = signed_div && src2_q[W-1];

    // Extending to 2W bits makes the truncated unsigned product equal the signed one.
    assign mul_sext = (op_q != OP_MULHU);
    assign mul_a    = {{W{mul_sext & src1_q[W-1]}}, src1_q};
    assign mul_b    = {{W{mul_sext & src2_q[W-1]}}, src2_q};
    assign product  = mul_a * mul_b;

    always_comb begin
        mul_res = '0;
        case (op_q)
            OP_MUL:           mul_res = product[W-1:0];
            OP_MULH, OP_MULHU: mul_res = product[2*W-1:W];
            default:          mul_res = '0;
        endcase
    end

    assign div_shift = {rem_q, quo_q[W-1]};
    assign div_diff  = div_shift - {1'b0, dvs_q};

    always_comb begin
        div_res = '0;
        if (src2_q == '0)
            div_res = is_mod ? src1_q : '1;
        else if (is_mod)
            div_res = neg_src1 ? negate(rem_q) : rem_q;
        else
            div_res = (neg_src1 ^ neg_src2) ? negate(quo_q) : quo_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        tag_d     = tag_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        out_tag_d = out_tag_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = bus.in_op;
                    src1_d = bus.in_src1;
                    src2_d = bus.in_src2;
                    tag_d  = bus.in_tag;
                    if (in_is_div) begin
                        state_d = S_DIV;
                        cnt_d   = DIV_LOAD;
                    end else begin
                        state_d = S_MUL;
                        cnt_d   = MUL_LOAD;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    state_d   = S_DONE;
                    result_d  = mul_res;
                    out_tag_d = tag_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DIV: begin
                if (cnt_q == DIV_LOAD) begin
                    rem_d = '0;
                    quo_d = neg_src1 ? negate(src1_q) : src1_q;
                    dvs_d = neg_src2 ? negate(src2_q) : src2_q;
                    cnt_d = cnt_q - CNT_ONE;
                end else if (cnt_q != '0) begin
                    if (!div_diff[W]) begin
                        rem_d = div_diff[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d   = S_DONE;
                    result_d  = div_res;
                    out_tag_d = tag_q;
                end
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush wins over completion and consumption alike.
        if (flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            result_d  = result_q;
            out_tag_d = out_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            tag_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            tag_q     <= tag_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            out_tag_q <= out_tag_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors with hand-computed results and latencies.
module tb_muldiv_unit;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 34;

    logic clk;
    logic rst;
    logic flush;
    logic busy;

    muldiv_unit_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

    muldiv_unit #(.DATA_WIDTH(32), .MUL_STAGES(2), .TAG_WIDTH(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is consumed at the coming edge when valid/ready hold and no kill is pending.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: unexpected result %h tag %h, none expected", bus.out_result, bus.out_tag);
            end else begin
                e = exp_q.pop_front();
                chk("result", bus.out_result, e.res);
                chk("tag", {27'd0, bus.out_tag}, {27'd0, e.tag});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        bus.in_tag   = tag;
        step();
        bus.in_valid = 1'b0;
        bus.in_src1  = 32'hDEAD_BEEF;
        bus.in_src2  = 32'h1234_5678;
        bus.in_op    = 3'd0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!bus.out_valid && k < 100) begin
            step();
            k++;
            chk("busy", busy, 1);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int lat);
        int k;
        exp_q.push_back('{res: exp, tag: tag});
        issue(op, a, b, tag);
        wait_valid(k);
        chk("latency", k, lat);
        step();
        chk("out_valid_after", bus.out_valid, 0);
        chk("in_ready_after", bus.in_ready, 1);
    endtask

    initial begin
        int k;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (2) step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_tag", {27'd0, bus.out_tag}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_post_rst", bus.in_ready, 1);

        // Multiplies
        run_op(3'd0, 32'd7,         32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, MUL_LAT);
        run_op(3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, MUL_LAT);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, MUL_LAT);
        run_op(3'd1, 32'hFFFFFFFF, 32'd1,        5'd4,  32'hFFFFFFFF, MUL_LAT);
        run_op(3'd2, 32'hFFFFFFFF, 32'd1,        5'd5,  32'h00000000, MUL_LAT);
        run_op(3'd0, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000, MUL_LAT);
        run_op(3'd7, 32'h00012345, 32'h00000678, 5'd7,  32'h00000000, MUL_LAT);

        // Divides
        run_op(3'd3, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, DIV_LAT);
        run_op(3'd5, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, DIV_LAT);
        run_op(3'd4, 32'd100,      32'd7,        5'd10, 32'd14,       DIV_LAT);
        run_op(3'd6, 32'd100,      32'd7,        5'd11, 32'd2,        DIV_LAT);

        // Divide boundaries
        run_op(3'd4, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, DIV_LAT);
        run_op(3'd6, 32'd5,        32'd0,        5'd13, 32'd5,        DIV_LAT);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, DIV_LAT);
        run_op(3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, DIV_LAT);
        run_op(3'd3, 32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFFF, DIV_LAT);
        run_op(3'd5, 32'hFFFFFFF9, 32'd0,        5'd17, 32'hFFFFFFF9, DIV_LAT);

        // Backpressure with a competing issue request
        bus.out_ready = 1'b0;
        exp_q.push_back('{res: 32'hFFFFFFFD, tag: 5'd18});
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 5'd18);
        wait_valid(k);
        chk("bp_latency", k, DIV_LAT);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd0;
        bus.in_src1  = 32'd3;
        bus.in_src2  = 32'd3;
        bus.in_tag   = 5'd30;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_result", bus.out_result, 32'hFFFFFFFD);
            chk("bp_out_tag", {27'd0, bus.out_tag}, 32'd18);
            chk("bp_in_ready", bus.in_ready, 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_released_valid", bus.out_valid, 0);
        chk("bp_released_ready", bus.in_ready, 1);
        chk("bp_released_busy", busy, 0);

        // Flush at t+10 of a divide, then a multiply issued at t+11
        issue(3'd4, 32'd1000, 32'd3, 5'd19);
        for (int i = 0; i < 9; i++) begin
            chk("flush_pre_valid", bus.out_valid, 0);
            step();
        end
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd0;
        bus.in_src1  = 32'd2;
        bus.in_src2  = 32'd2;
        bus.in_tag   = 5'd31;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_idle_ready", bus.in_ready, 1);
        chk("flush_busy", busy, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        run_op(3'd0, 32'd6, 32'd7, 5'd20, 32'd42, MUL_LAT);

        // Reset mid-multiply
        issue(3'd0, 32'd9, 32'd9, 5'd21);
        chk("mid_mul_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("rst_mul_valid", bus.out_valid, 0);
        chk("rst_mul_result", bus.out_result, 0);
        chk("rst_mul_tag", {27'd0, bus.out_tag}, 0);
        chk("rst_mul_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("rst_mul_ready", bus.in_ready, 1);

        // Reset while a result is held in DONE
        bus.out_ready = 1'b0;
        issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd22);
        wait_valid(k);
        chk("held_latency", k, MUL_LAT);
        chk("held_result", bus.out_result, 32'hFFFFFFEB);
        chk("held_tag", {27'd0, bus.out_tag}, 32'd22);
        rst = 1'b1;
        step();
        chk("rst_done_valid", bus.out_valid, 0);
        chk("rst_done_result", bus.out_result, 0);
        chk("rst_done_tag", {27'd0, bus.out_tag}, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_done_ready", bus.in_ready, 1);
        run_op(3'd4, 32'd100, 32'd7, 5'd23, 32'd14, DIV_LAT);

        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle integer multiply/divide unit for the execute stage. It replaces single-cycle combinational `*`, `/` and `%` with a registered multiplier and an iterative radix-2 divider, parametrised in data width and multiplier latency. It holds one operation at a time, using a valid/ready handshake on both the issue and result sides. The execute stage uses `busy` to raise `stallreq` while an operation is in flight.

Parameters:
DATA_WIDTH, 32, operand/result width W (even, >=8)
MUL_STAGES, 2, multiply latency in cycles from accept to out_valid (>=1)
TAG_WIDTH, 5, width of destination-register tag carried with each op

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush  in  1  synchronous kill of in-flight/held op
in_valid  in  1  issue request
in_ready  out  1  unit can accept; = (state==IDLE) && !flush && !rst
in_op  in  3  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved
in_src1  in  W  multiplicand / dividend
in_src2  in  W  multiplier / divisor
in_tag  in  TAG_WIDTH  destination tag, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  W  result
out_tag  out  TAG_WIDTH  tag of result
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, out_valid=0, out_result=0, out_tag=0, all counters 0. rst overrides flush and any handshake; an op in flight is discarded.
- Accept: in_valid && in_ready at edge t. src1, src2, op and tag are latched; in_* are don't-care afterwards.
- States: IDLE, MUL, DIV, DONE.
- IDLE -> MUL (op 0-2, 7) or DIV (op 3-6) on accept.
- MUL: counter counts MUL_STAGES-1 cycles, then -> DONE. out_valid=1 from cycle t+MUL_STAGES.
  - Product is the full 2W product. Operands are sign-extended to W+1 bits for MUL/MULH, zero-extended for MULHU.
  - MUL returns [W-1:0]. MULH/MULHU return [2W-1:W].
  - The multiplier may be retimed across stages, but latency is exactly MUL_STAGES.
  - Op 7 returns 0 with MUL latency.
- DIV: first edge after accept latches absolute values (signed ops) or raw values (unsigned). Restoring division then produces one quotient bit per cycle for W cycles. Final sign fix-up registers into DONE. out_valid=1 from cycle t+W+2, a fixed latency for all divides.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divisor==0: quotient = all-ones, remainder = src1 (raw), same latency.
  - Signed overflow (min / -1): quotient = min, remainder = 0, with no special casing needed.
- DONE: out_valid=1. out_result and out_tag are stable until out_valid && out_ready at an edge, then -> IDLE. in_ready rises the following cycle; there is no same-cycle re-issue.
- out_valid=0 in every state except DONE. out_result/out_tag keep their last value outside DONE and are not zeroed.
- flush=1 at an edge: any state -> IDLE, out_valid=0 next cycle, and the held result is dropped.
  - in_valid in a flush cycle is not accepted (in_ready=0).
  - flush and out_ready in the same DONE cycle: the result counts as not consumed; the consumer must honour the flush.
- Counters saturate/clear on exit. Divider iteration count is exactly W, independent of operand values.

Test Plan:
1. W=32, MUL_STAGES=2. MUL 7 x 0xFFFFFFFD accepted at t -> out_valid at t+2, out_result 0xFFFFFFEB, tag echoed. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
2. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. MOD same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. MODU 100 % 7 -> 2. Each has out_valid first at t+34, and busy=1 for t+1..t+34.
3. Boundaries: DIVU 5/0 -> 0xFFFFFFFF. MODU 5%0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. MOD same operands -> 0.
4. Backpressure: complete a DIV, hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_result/out_tag constant, in_ready=0, no second accept. Raise out_ready -> in_ready=1 the next cycle.
5. Flush at t+10 of a DIV -> out_valid never rises, in_ready=1 at t+11. A MUL issued at t+11 -> correct result at t+13.
6. rst pulsed mid-MUL and in DONE -> out_valid=0, out_result=0, out_tag=0 the cycle after, in_ready=1 once rst drops. A new DIV then completes with the correct latency.
